// File: rtl/reg_file_pkg.sv
// Shared defaults for the scoreboarded register file.
// Register index 0 is hardwired to zero and carries no pending state.
package reg_file_pkg;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NUM_RD = 2;
    localparam int unsigned DEF_CNT_W  = 2;
    localparam int unsigned ZERO_REG   = 0;
endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter of outstanding writes to one register.
// Clear wins; simultaneous inc and dec holds; dec at zero pulses underflow.
module pend_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat,
    output logic             o_underflow
);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && (r_cnt != CntMax)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt       = r_cnt;
    assign o_sat       = (r_cnt == CntMax);
    // A flush is not a protocol error even if a stray writeback coincides.
    assign o_underflow = i_dec && !i_clr && (r_cnt == '0);
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write bypass and per-register pending-write
// scoreboard that stalls issue on RAW and counter-overflow hazards.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_RD-1:0]        rd_used,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dest,
    input  logic                     flush,
    output logic                     stall,
    output logic                     err
);
    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [CNT_W-1:0]  w_cnt  [DEPTH];
    logic [DEPTH-1:0]  w_sat;
    logic [DEPTH-1:0]  w_unf;
    logic              w_wb;
    logic              w_accept;
    logic              w_src_haz;
    logic              w_dest_haz;
    logic              r_err;

    assign w_wb = wr_en && (wr_addr != ZERO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_wb) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] = (w_ra == ZERO)                  ? '0      :
                                             (wr_en && (wr_addr == w_ra))    ? wr_data :
                                                                               r_regs[w_ra];
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_cnt
        if (r == 0) begin : g_zero
            assign w_cnt[r] = '0;
            assign w_sat[r] = 1'b0;
            assign w_unf[r] = 1'b0;
        end else begin : g_reg
            pend_counter #(
                .CNT_W (CNT_W)
            ) u_pend (
                .clk         (clk),
                .rst         (rst),
                .i_inc       (w_accept && (iss_dest == ADDR_W'(r))),
                .i_dec       (wr_en && (wr_addr == ADDR_W'(r))),
                .i_clr       (flush),
                .o_cnt       (w_cnt[r]),
                .o_sat       (w_sat[r]),
                .o_underflow (w_unf[r])
            );
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] w_a;
        w_a       = ZERO;
        w_src_haz = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_a = rd_addr[k*ADDR_W +: ADDR_W];
            // The last outstanding write landing this cycle is covered by the bypass.
            if (rd_used[k] && (w_a != ZERO) && (w_cnt[w_a] != '0) &&
                !(wr_en && (wr_addr == w_a) && (w_cnt[w_a] == CNT_W'(1)))) begin
                w_src_haz = 1'b1;
            end
        end
        w_dest_haz = (iss_dest != ZERO) && w_sat[iss_dest] &&
                     !(wr_en && (wr_addr == iss_dest));
    end

    assign stall    = iss_valid && !flush && (w_src_haz || w_dest_haz);
    assign w_accept = iss_valid && !flush && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (|w_unf) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: array/count model checked every negedge,
// plus literal expectations at the key scenarios.
module tb_reg_file_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int CW = 2;
    localparam int CMAX = 3;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_used;
    logic             iss_valid;
    logic [AW-1:0]    iss_dest;
    logic             flush;
    logic             stall;
    logic             err;

    int vectors;
    int miscompares;

    logic [DW-1:0] m_regs [32];
    int            m_cnt  [32];
    bit            m_err;

    reg_file_sb #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_used   (rd_used),
        .iss_valid (iss_valid),
        .iss_dest  (iss_dest),
        .flush     (flush),
        .stall     (stall),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int addr_of(int k);
        return int'(rd_addr[k*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] exp_rd(int k);
        int a;
        a = addr_of(k);
        if (a == 0) return '0;
        if (wr_en && (int'(wr_addr) == a)) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_stall();
        bit haz;
        int a;
        int d;
        haz = 1'b0;
        if (!iss_valid || flush) return 1'b0;
        for (int k = 0; k < NR; k++) begin
            a = addr_of(k);
            if (rd_used[k] && a != 0 && m_cnt[a] > 0 &&
                !(wr_en && int'(wr_addr) == a && m_cnt[a] == 1)) haz = 1'b1;
        end
        d = int'(iss_dest);
        if (d != 0 && m_cnt[d] == CMAX && !(wr_en && int'(wr_addr) == d)) haz = 1'b1;
        return haz;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
    endtask

    always @(negedge rst) model_clear();

    // Model advance on each active edge, using the pre-edge inputs.
    always @(posedge clk) begin
        if (rst) begin
            bit acc;
            int d;
            int w;
            acc = iss_valid && !flush && !exp_stall();
            d   = int'(iss_dest);
            w   = int'(wr_addr);
            if (wr_en && w != 0) m_regs[w] = wr_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            end else begin
                if (wr_en && w != 0 && m_cnt[w] == 0) m_err = 1'b1;
                if (!(acc && d != 0 && wr_en && w == d)) begin
                    if (acc && d != 0 && m_cnt[d] < CMAX) m_cnt[d] = m_cnt[d] + 1;
                    if (wr_en && w != 0 && m_cnt[w] > 0) m_cnt[w] = m_cnt[w] - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NR; k++)
            chk(k == 0 ? "model rd_data0" : "model rd_data1",
                64'(rd_data[k*DW +: DW]), 64'(exp_rd(k)));
        chk("model stall", 64'(stall), 64'(exp_stall()));
        chk("model err", 64'(err), 64'(m_err));
    end

    task automatic idle();
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        rd_used   = '0;
        iss_valid = 1'b0;
        iss_dest  = '0;
        flush     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d);
        idle();
        iss_valid = 1'b1;
        iss_dest  = AW'(d);
    endtask

    task automatic wb(input int a, input logic [DW-1:0] v);
        idle();
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = v;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_clear();
        rst = 1'b0;
        idle();
        #1;
        chk("reset rd_data", 64'(rd_data), 64'h0);
        chk("reset stall", 64'(stall), 64'h0);
        chk("reset err", 64'(err), 64'h0);
        #12 rst = 1'b1;
        tick();

        // Write r5 then read it from the array
        issue(5); #1; chk("iss r5 stall", 64'(stall), 64'h0); tick();
        wb(5, 32'hDEADBEEF); tick();
        idle(); rd_addr[AW-1:0] = 5'd5; #1;
        chk("r5 array read", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
        tick();

        // r0 discards writes, even bypassed
        wb(0, 32'h1234); rd_addr[AW-1:0] = 5'd0; #1;
        chk("r0 bypass", 64'(rd_data[DW-1:0]), 64'h0);
        tick();
        idle(); #1; chk("r0 array", 64'(rd_data[DW-1:0]), 64'h0); tick();

        // Same-cycle bypass on port 1
        issue(7); tick();
        wb(7, 32'hA5A5A5A5); rd_addr[2*AW-1:AW] = 5'd7; #1;
        chk("r7 bypass p1", 64'(rd_data[2*DW-1:DW]), 64'hA5A5A5A5);
        tick();

        // RAW on r3, resolved by same-cycle writeback
        issue(3); tick();
        issue(0); rd_used = 2'b01; rd_addr[AW-1:0] = 5'd3; #1;
        chk("raw r3 stall", 64'(stall), 64'h1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; #1;
        chk("raw r3 bypass", 64'(stall), 64'h0);
        tick();

        // Saturation of r4 at three outstanding writes
        for (int i = 0; i < 3; i++) begin
            issue(4); #1; chk("r4 fill", 64'(stall), 64'h0); tick();
        end
        issue(4); #1; chk("r4 full", 64'(stall), 64'h1); tick();
        wb(4, 32'h44); tick();
        issue(4); #1; chk("r4 reissue", 64'(stall), 64'h0); tick();
        issue(4); wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h45; #1;
        chk("r4 full+wb", 64'(stall), 64'h0);
        tick();

        // Writeback without a pending count raises sticky err
        idle(); #1; chk("err before", 64'(err), 64'h0);
        wb(9, 32'h99); tick();
        idle(); rd_addr[AW-1:0] = 5'd9; #1;
        chk("r9 written", 64'(rd_data[DW-1:0]), 64'h99);
        chk("err set", 64'(err), 64'h1);
        tick();

        // Flush clears pending counts, ignores same-cycle issue
        issue(2); tick();
        issue(2); flush = 1'b1; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAA; #1;
        chk("flush stall", 64'(stall), 64'h0);
        tick();
        issue(0); rd_used = 2'b11; rd_addr = {5'd4, 5'd2}; #1;
        chk("post flush", 64'(stall), 64'h0);
        chk("err held", 64'(err), 64'h1);
        tick();
        idle(); rd_addr[AW-1:0] = 5'd10; #1;
        chk("flush write", 64'(rd_data[DW-1:0]), 64'hAA);
        tick();

        // Asynchronous reset mid-sequence with r6 pending
        issue(6); tick();
        issue(0); rd_used = 2'b11; rd_addr = {5'd6, 5'd5};
        #2 rst = 1'b0;
        #1;
        chk("rst rd_data", 64'(rd_data), 64'h0);
        chk("rst stall", 64'(stall), 64'h0);
        chk("rst err", 64'(err), 64'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        tick();
        issue(6); tick();
        wb(6, 32'h66); tick();
        idle(); rd_addr[AW-1:0] = 5'd6; #1;
        chk("after rst r6", 64'(rd_data[DW-1:0]), 64'h66);
        chk("after rst err", 64'(err), 64'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, register index width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of read ports.
REQ-004 Parameter CNT_W, default 2, width of each pending-write counter; max outstanding writes per register = 2**CNT_W-1.
REQ-005 Port clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-low.
REQ-007 Port wr_en  in  1  writeback valid.
REQ-008 Port wr_addr  in  ADDR_W  writeback register index.
REQ-009 Port wr_data  in  DATA_W  writeback value.
REQ-010 Port rd_addr  in  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 Port rd_data  out  NUM_RD*DATA_W  read values, port k at [k*DATA_W +: DATA_W].
REQ-012 Port rd_used  in  NUM_RD  port k is a real source of the issuing instruction.
REQ-013 Port iss_valid  in  1  instruction requests issue this cycle.
REQ-014 Port iss_dest  in  ADDR_W  destination of issuing instruction (0 = none).
REQ-015 Port flush  in  1  pipeline flush; clears all pending state.
REQ-016 Port stall  out  1  issue refused this cycle (combinational).
REQ-017 Port err  out  1  sticky protocol-error flag.

Function
REQ-018 Register 0 SHALL read 0 always; writes to index 0 SHALL be discarded.
REQ-019 rd_data SHALL be combinational: wr_data if wr_en & wr_addr==rd_addr & rd_addr!=0 (same-cycle bypass), else stored value.
REQ-020 Array write SHALL occur at rising clk when wr_en & wr_addr!=0; latency to array read = 1 cycle, to bypassed read = 0.
REQ-021 Each register r>0 SHALL hold pend_cnt[r]; register 0 has none (always 0).
REQ-022 Source hazard on port k: rd_used[k] & rd_addr_k!=0 & pend_cnt!=0, except when wr_en & wr_addr==rd_addr_k & pend_cnt==1 (resolved by bypass).
REQ-023 Dest hazard: iss_dest!=0 & pend_cnt[iss_dest]==2**CNT_W-1 and no same-cycle writeback to iss_dest.
REQ-024 stall = iss_valid & ~flush & (any source hazard | dest hazard); stall SHALL be 0 when iss_valid=0.
REQ-025 Issue accepted = iss_valid & ~stall & ~flush; accepted issue with iss_dest!=0 SHALL increment pend_cnt[iss_dest].
REQ-026 wr_en & wr_addr!=0 SHALL decrement pend_cnt[wr_addr].
REQ-027 Simultaneous increment and decrement on same register SHALL leave count unchanged.
REQ-028 Writeback to register with pend_cnt==0 SHALL still write data, leave count 0 (no wrap), and set err.
REQ-029 flush SHALL zero all counters next edge, ignore same-cycle issue, still perform same-cycle data write, and not set err.
REQ-030 err SHALL stay 1 until reset.

Reset
REQ-031 rst low SHALL immediately clear all registers, all pend_cnt and err to 0; stall then depends only on inputs (0 when iss_valid=0).
REQ-032 Reset asserted mid-operation SHALL discard pending writes and counts; first edge after rst deassertion behaves as from idle.

Structure
REQ-033 Package reg_file_pkg SHALL hold parameter defaults (DATA_W, ADDR_W, NUM_RD, CNT_W) and the zero-register index constant.
REQ-034 One sub-module pend_counter (CNT_W up/down counter with saturation flag, inc/dec/clr inputs, underflow pulse), instantiated per register 1..depth-1.

Verification
REQ-035 Reset, write r5=0xDEADBEEF, next cycle read port0 r5 -> 0xDEADBEEF; write r0=0x1234 -> read r0 = 0.
REQ-036 wr_en r7=0xA5A5A5A5 with rd_addr port1=7 same cycle -> rd_data port1 = 0xA5A5A5A5 combinationally.
REQ-037 Issue dest r3; next cycle iss_valid, rd_used[0], rd_addr0=3, no writeback -> stall=1; same with wr_en r3 -> stall=0.
REQ-038 CNT_W=2: three issues to r4 accepted, fourth -> stall=1; one writeback r4 -> count 2, reissue accepted.
REQ-039 Writeback r9 with pend_cnt[r9]=0 -> data written, err=1 held; flush with r2 pending -> count 0, err unchanged.
REQ-040 Assert rst low mid-sequence with pending r6 -> all reads 0, stall 0, err 0 immediately.
